// File: rtl/iob_eth_mdio_pkg.sv
// iob_eth_mdio_pkg: shared types and constants for the Clause 22 MDIO responder.
package iob_eth_mdio_pkg;

    // Protocol FSM states, in frame order.
    typedef enum logic [3:0] {
        StIdle,
        StSt,
        StOp,
        StPhyad,
        StRegad,
        StTa,
        StRdData,
        StWrData,
        StIgnore
    } mdio_state_t;

    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;

    localparam logic [4:0] REG_BMCR   = 5'd0;
    localparam logic [4:0] REG_BMSR   = 5'd1;
    localparam logic [4:0] REG_PHYID1 = 5'd2;
    localparam logic [4:0] REG_PHYID2 = 5'd3;
    localparam logic [4:0] REG_ANAR   = 5'd4;

    localparam logic [15:0] BMCR_RST  = 16'h1140;
    localparam logic [15:0] BMSR_BASE = 16'h7949;
    localparam logic [15:0] ANAR_RST  = 16'h01E1;

    // Registers 16..31 are the writable scratch block.
    function automatic logic is_scratch(input logic [4:0] addr);
        return addr[4];
    endfunction

endpackage

// File: rtl/iob_eth_mdio_resp_regs.sv
// iob_eth_mdio_resp_regs: 32x16 management register file of the MDIO responder.
// Optional feature macro: IOB_ETH_MDIO_PREAMBLE_SUPPRESS_EN (sets register 1 bit 6).
module iob_eth_mdio_resp_regs
    import iob_eth_mdio_pkg::*;
#(
    parameter logic [15:0] PHY_ID1 = 16'h0022,
    parameter logic [15:0] PHY_ID2 = 16'h1622
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_link_up,
    input  logic [4:0]  i_rd_addr,
    output logic [15:0] o_rd_data,
    input  logic        i_wr_en,
    input  logic [4:0]  i_wr_addr,
    input  logic [15:0] i_wr_data,
    output logic        o_soft_rst,
    output logic        o_loopback
);

    logic [15:0] r_reg0;
    logic [15:0] r_reg4;
    logic [15:0] r_scratch [16];
    logic        r_soft_rst;
    logic [15:0] w_bmsr;

    // Register state; a soft reset reloads the same set as the hard reset one cycle after the write.
    always_ff @(posedge i_clk) begin
        if (!i_rstn || r_soft_rst) begin
            r_reg0     <= BMCR_RST;
            r_reg4     <= ANAR_RST;
            r_soft_rst <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_scratch[i] <= '0;
            end
        end else begin
            r_soft_rst <= 1'b0;
            if (i_wr_en) begin
                if (i_wr_addr == REG_BMCR) begin
                    // Bit 15 never sticks: it only launches the soft reset.
                    r_reg0     <= i_wr_data & 16'h7FFF;
                    r_soft_rst <= i_wr_data[15];
                end else if (i_wr_addr == REG_ANAR) begin
                    r_reg4 <= i_wr_data;
                end else if (is_scratch(i_wr_addr)) begin
                    r_scratch[i_wr_addr[3:0]] <= i_wr_data;
                end
            end
        end
    end

    // Status register composition and read mux.
    always_comb begin
        w_bmsr    = BMSR_BASE;
        w_bmsr[2] = i_link_up;
`ifdef IOB_ETH_MDIO_PREAMBLE_SUPPRESS_EN
        w_bmsr[6] = 1'b1;
`else
        w_bmsr[6] = 1'b0;
`endif
        o_rd_data = '0;
        if (is_scratch(i_rd_addr)) begin
            o_rd_data = r_scratch[i_rd_addr[3:0]];
        end else begin
            case (i_rd_addr)
                REG_BMCR:   o_rd_data = r_reg0;
                REG_BMSR:   o_rd_data = w_bmsr;
                REG_PHYID1: o_rd_data = PHY_ID1;
                REG_PHYID2: o_rd_data = PHY_ID2;
                REG_ANAR:   o_rd_data = r_reg4;
                default:    o_rd_data = '0;
            endcase
        end
    end

    assign o_soft_rst = r_soft_rst;
    assign o_loopback = r_reg0[14];

endmodule

// File: rtl/iob_eth_mdio_resp.sv
// iob_eth_mdio_resp: PHY-side Clause 22 MDIO responder, oversampling MDC/MDIO on clk_i.
// Optional feature macro: IOB_ETH_MDIO_PREAMBLE_SUPPRESS_EN (accept ST after a single one).
module iob_eth_mdio_resp
    import iob_eth_mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter logic [15:0] PHY_ID1      = 16'h0022,
    parameter logic [15:0] PHY_ID2      = 16'h1622,
    parameter int unsigned PREAMBLE_MIN = 32
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic mdc_i,
    input  logic mdio_i,
    output logic mdio_o,
    output logic mdio_oe_o,
    input  logic link_up_i,
    output logic soft_rst_o,
    output logic loopback_o
);

`ifdef IOB_ETH_MDIO_PREAMBLE_SUPPRESS_EN
    localparam int unsigned PreMin = 1;
`else
    localparam int unsigned PreMin = PREAMBLE_MIN;
`endif

    logic        r_mdc_s1, r_mdc_s2, r_mdc_d;
    logic        r_mdio_s1, r_mdio_s2;
    mdio_state_t r_state, w_state_d;
    logic [5:0]  r_pre_cnt, w_pre_cnt_d;
    logic [4:0]  r_bit_cnt, w_bit_cnt_d;
    logic        r_op, w_op_d;
    logic        r_is_rd, w_is_rd_d;
    logic [4:0]  r_phyad, w_phyad_d;
    logic [4:0]  r_regad, w_regad_d;
    logic [15:0] r_shift, w_shift_d;
    logic        r_mdio_o, w_mdio_o_d;
    logic        r_mdio_oe, w_mdio_oe_d;

    logic        w_tick;
    logic        w_mdio;
    logic [4:0]  w_regad_next;
    logic [15:0] w_rd_data;
    logic        w_wr_en;
    logic [15:0] w_wr_data;

    assign w_tick       = r_mdc_s2 & ~r_mdc_d;
    assign w_mdio       = r_mdio_s2;
    assign w_regad_next = {r_regad[3:0], w_mdio};
    assign w_wr_data    = {r_shift[14:0], w_mdio};

    // Synchronizers and MDC edge register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_mdc_s1  <= 1'b0;
            r_mdc_s2  <= 1'b0;
            r_mdc_d   <= 1'b0;
            r_mdio_s1 <= 1'b1;
            r_mdio_s2 <= 1'b1;
        end else begin
            r_mdc_s1  <= mdc_i;
            r_mdc_s2  <= r_mdc_s1;
            r_mdc_d   <= r_mdc_s2;
            r_mdio_s1 <= mdio_i;
            r_mdio_s2 <= r_mdio_s1;
        end
    end

    // FSM and datapath state registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state   <= StIdle;
            r_pre_cnt <= '0;
            r_bit_cnt <= '0;
            r_op      <= 1'b0;
            r_is_rd   <= 1'b0;
            r_phyad   <= '0;
            r_regad   <= '0;
            r_shift   <= '0;
            r_mdio_o  <= 1'b0;
            r_mdio_oe <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_pre_cnt <= w_pre_cnt_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_op      <= w_op_d;
            r_is_rd   <= w_is_rd_d;
            r_phyad   <= w_phyad_d;
            r_regad   <= w_regad_d;
            r_shift   <= w_shift_d;
            r_mdio_o  <= w_mdio_o_d;
            r_mdio_oe <= w_mdio_oe_d;
        end
    end

    // Frame decoder: all protocol action happens on MDC rising-edge ticks.
    always_comb begin
        w_state_d   = r_state;
        w_pre_cnt_d = r_pre_cnt;
        w_bit_cnt_d = r_bit_cnt;
        w_op_d      = r_op;
        w_is_rd_d   = r_is_rd;
        w_phyad_d   = r_phyad;
        w_regad_d   = r_regad;
        w_shift_d   = r_shift;
        w_mdio_o_d  = r_mdio_o;
        w_mdio_oe_d = r_mdio_oe;
        w_wr_en     = 1'b0;
        if (w_tick) begin
            unique case (r_state)
                StIdle: begin
                    if (w_mdio) begin
                        if (r_pre_cnt != 6'd63) begin
                            w_pre_cnt_d = r_pre_cnt + 6'd1;
                        end
                    end else begin
                        // This zero is the first ST bit when the preamble was long enough.
                        w_pre_cnt_d = '0;
                        if (32'(r_pre_cnt) >= PreMin) begin
                            w_state_d = StSt;
                        end
                    end
                end
                StSt: begin
                    w_bit_cnt_d = '0;
                    w_state_d   = w_mdio ? StOp : StIdle;
                end
                StOp: begin
                    w_op_d      = w_mdio;
                    w_bit_cnt_d = r_bit_cnt + 5'd1;
                    if (r_bit_cnt[0]) begin
                        w_bit_cnt_d = '0;
                        if ({r_op, w_mdio} == MDIO_OP_RD) begin
                            w_is_rd_d = 1'b1;
                            w_state_d = StPhyad;
                        end else if ({r_op, w_mdio} == MDIO_OP_WR) begin
                            w_is_rd_d = 1'b0;
                            w_state_d = StPhyad;
                        end else begin
                            w_state_d = StIdle;
                        end
                    end
                end
                StPhyad: begin
                    w_phyad_d   = {r_phyad[3:0], w_mdio};
                    w_bit_cnt_d = r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'd4) begin
                        w_bit_cnt_d = '0;
                        w_state_d   = StRegad;
                    end
                end
                StRegad: begin
                    w_regad_d   = w_regad_next;
                    w_bit_cnt_d = r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'd4) begin
                        w_bit_cnt_d = '0;
                        if (r_phyad != PHY_ADDR) begin
                            w_state_d = StIgnore;
                        end else begin
                            w_state_d = StTa;
                            // Snapshot now so later link changes cannot alter this read.
                            if (r_is_rd) begin
                                w_shift_d = w_rd_data;
                            end
                        end
                    end
                end
                StTa: begin
                    w_bit_cnt_d = r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'd0) begin
                        if (r_is_rd) begin
                            w_mdio_oe_d = 1'b1;
                            w_mdio_o_d  = 1'b0;
                        end
                    end else begin
                        w_bit_cnt_d = '0;
                        if (r_is_rd) begin
                            w_mdio_o_d = r_shift[15];
                            w_shift_d  = {r_shift[14:0], 1'b0};
                            w_state_d  = StRdData;
                        end else begin
                            w_state_d = StWrData;
                        end
                    end
                end
                StRdData: begin
                    if (r_bit_cnt == 5'd15) begin
                        // Initiator samples D0 on this edge; release the line.
                        w_mdio_oe_d = 1'b0;
                        w_mdio_o_d  = 1'b0;
                        w_bit_cnt_d = '0;
                        w_state_d   = StIdle;
                    end else begin
                        w_mdio_o_d  = r_shift[15];
                        w_shift_d   = {r_shift[14:0], 1'b0};
                        w_bit_cnt_d = r_bit_cnt + 5'd1;
                    end
                end
                StWrData: begin
                    w_shift_d   = w_wr_data;
                    w_bit_cnt_d = r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'd15) begin
                        w_wr_en     = 1'b1;
                        w_bit_cnt_d = '0;
                        w_state_d   = StIdle;
                    end
                end
                StIgnore: begin
                    // TA plus 16 data bits of a frame for another PHY.
                    w_bit_cnt_d = r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'd17) begin
                        w_bit_cnt_d = '0;
                        w_state_d   = StIdle;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase
        end
    end

    iob_eth_mdio_resp_regs #(
        .PHY_ID1 (PHY_ID1),
        .PHY_ID2 (PHY_ID2)
    ) u_regs (
        .i_clk      (clk_i),
        .i_rstn     (rstn_i),
        .i_link_up  (link_up_i),
        .i_rd_addr  (w_regad_next),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (r_regad),
        .i_wr_data  (w_wr_data),
        .o_soft_rst (soft_rst_o),
        .o_loopback (loopback_o)
    );

    assign mdio_o    = r_mdio_o;
    assign mdio_oe_o = r_mdio_oe;

endmodule
